// File: rtl/drfa_mem_pkg.sv
// Shared memory-path definitions for the bank selector / bank read controller
// pair: default bank and address widths, the read FSM state type and the
// latency-counter sizing.
package drfa_mem_pkg;

  localparam int DEF_BANK_WIDTH   = 2;
  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int MAX_READ_LATENCY = 4;

  // Wide enough to hold MAX_READ_LATENCY.
  localparam int LAT_CNT_WIDTH = $clog2(MAX_READ_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } bank_rd_state_t;

endpackage

// File: rtl/read_latency_counter.sv
// Loadable down-counter that times the RAM read latency. The last flag is high
// while the count equals 1, i.e. in the cycle the RAM data is valid.
module read_latency_counter
  import drfa_mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [LAT_CNT_WIDTH-1:0] load_val,
  input  logic                     dec,
  output logic                     last
);

  logic [LAT_CNT_WIDTH-1:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == LAT_CNT_WIDTH'(1));

endmodule

// File: rtl/bank_read_controller.sv
// Single-outstanding read controller for the banked data RAM. Latches the bank
// from the selector at request acceptance, issues one RAM read strobe, waits
// READ_LATENCY cycles and presents the word on a valid/ready response channel.
// Optional feature macro: BANK_READ_PARITY_EN adds the rsp_parity output.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a request; latches {bank_sel, req_addr} on accept
// ST_ISSUE | mem_en high for one cycle, latency counter loaded
// ST_WAIT  | counting down; mem_rdata captured when the counter reads 1
// ST_RESP  | rsp_valid high, response held until rsp_ready
module bank_read_controller
  import drfa_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int BANK_WIDTH   = DEF_BANK_WIDTH,
  parameter int READ_LATENCY = 1   // legal range 1..MAX_READ_LATENCY
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [BANK_WIDTH-1:0]            bank_sel,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             mem_en,
  output logic [BANK_WIDTH+ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [BANK_WIDTH-1:0]            rsp_bank
`ifdef BANK_READ_PARITY_EN
  ,
  output logic                             rsp_parity
`endif
);

  bank_rd_state_t state, next_state;

  logic accept;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_last;
  logic capture;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept)               next_state = ST_ISSUE;
      ST_ISSUE:                           next_state = ST_WAIT;
      ST_WAIT:  if (cnt_last)             next_state = ST_RESP;
      ST_RESP:  if (rsp_ready)            next_state = ST_IDLE;
      default:                            next_state = ST_IDLE;
    endcase
  end

  // Output decode; req_ready is gated by rst_n so it reads 0 throughout reset.
  always_comb begin
    req_ready = 1'b0;
    mem_en    = 1'b0;
    rsp_valid = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE:  req_ready = rst_n;
      ST_ISSUE: begin
        mem_en   = 1'b1;
        cnt_load = 1'b1;
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        capture = cnt_last;
      end
      ST_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = req_valid && req_ready;

  read_latency_counter u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (LAT_CNT_WIDTH'(READ_LATENCY)),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  // mem_addr doubles as the latched {bank, addr}; it only changes on accept,
  // so it holds its value outside the strobe cycle and later bank_sel changes
  // cannot reach the in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
    end else if (accept) begin
      mem_addr <= {bank_sel, req_addr};
    end
  end

  // Response capture in the single cycle the RAM data is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_bank <= '0;
    end else if (capture) begin
      rsp_data <= mem_rdata;
      rsp_bank <= mem_addr[BANK_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
    end
  end

`ifdef BANK_READ_PARITY_EN
  // Parity registered alongside rsp_data so both change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_parity <= 1'b0;
    end else if (capture) begin
      rsp_parity <= ^mem_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_bank_read_controller.sv
// Bench for bank_read_controller: two instances (READ_LATENCY 1 and 3) share
// clock and reset. A RAM model returns the correct word only in the cycle it
// is due and the complement otherwise, so mis-timed capture shows up as a
// data error. Expected responses come from the bench RAM image indexed by the
// requested {bank, addr}.
module tb_bank_read_controller;

  logic       clk;
  logic       rst_n;
  logic [1:0] bank_sel  [2];
  logic       req_valid [2];
  logic       req_ready [2];
  logic [7:0] req_addr  [2];
  logic       mem_en    [2];
  logic [9:0] mem_addr  [2];
  logic [7:0] mem_rdata [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_data  [2];
  logic [1:0] rsp_bank  [2];
`ifdef BANK_READ_PARITY_EN
  logic       rsp_parity [2];
`endif

  int lat [2] = '{1, 3};

  logic [7:0] ram [1024];
  int         cyc = 0;
  int         due  [2] = '{-1, -1};
  logic [7:0] word [2] = '{8'h00, 8'h00};

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bank_read_controller #(
      .READ_LATENCY (g == 0 ? 1 : 3)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bank_sel  (bank_sel[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr[g]),
      .mem_en    (mem_en[g]),
      .mem_addr  (mem_addr[g]),
      .mem_rdata (mem_rdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_data  (rsp_data[g]),
      .rsp_bank  (rsp_bank[g])
`ifdef BANK_READ_PARITY_EN
      ,
      .rsp_parity (rsp_parity[g])
`endif
    );

    // RAM model: word is valid exactly lat cycles after the strobe cycle.
    always @(negedge clk) begin
      if (mem_en[g] === 1'b1) begin
        due[g]  = cyc + lat[g];
        word[g] = ram[mem_addr[g]];
      end
      mem_rdata[g] = (cyc == due[g]) ? word[g] : ~word[g];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One complete read on unit u, checked cycle by cycle from the caller's
  // negedge. stall = cycles rsp_ready stays low in RESP; flip changes bank_sel
  // right after acceptance.
  task automatic do_read(input int u, input logic [1:0] bank, input logic [7:0] addr,
                         input int stall, input bit flip);
    logic [9:0] exp_a;
    logic [7:0] exp_d;
    int t;
    exp_a = {bank, addr};
    exp_d = ram[exp_a];
    t = 0;
    while (req_ready[u] !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_idle", 32'(req_ready[u]), 32'd1);
    bank_sel[u]  = bank;
    req_addr[u]  = addr;
    req_valid[u] = 1'b1;
    @(negedge clk);
    req_valid[u] = 1'b0;
    req_addr[u]  = 8'($urandom);
    if (flip) bank_sel[u] = bank ^ 2'($urandom_range(1, 3));
    chk("mem_en_issue", 32'(mem_en[u]), 32'd1);
    chk("mem_addr", 32'(mem_addr[u]), 32'(exp_a));
    chk("req_ready_busy", 32'(req_ready[u]), 32'd0);
    for (int k = 0; k < lat[u]; k++) begin
      @(negedge clk);
      chk("mem_en_wait", 32'(mem_en[u]), 32'd0);
      chk("rsp_valid_early", 32'(rsp_valid[u]), 32'd0);
    end
    @(negedge clk);
    chk("rsp_valid_rise", 32'(rsp_valid[u]), 32'd1);
    chk("rsp_data", 32'(rsp_data[u]), 32'(exp_d));
    chk("rsp_bank", 32'(rsp_bank[u]), 32'(bank));
`ifdef BANK_READ_PARITY_EN
    chk("rsp_parity", 32'(rsp_parity[u]), 32'(^exp_d));
`endif
    for (int k = 0; k < stall; k++) begin
      req_valid[u] = 1'b1;
      req_addr[u]  = 8'($urandom);
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid[u]), 32'd1);
      chk("stall_data", 32'(rsp_data[u]), 32'(exp_d));
      chk("stall_ready", 32'(req_ready[u]), 32'd0);
      chk("stall_mem_en", 32'(mem_en[u]), 32'd0);
    end
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b1;
    @(negedge clk);
    rsp_ready[u] = 1'b0;
    chk("post_hs_valid", 32'(rsp_valid[u]), 32'd0);
    chk("post_hs_ready", 32'(req_ready[u]), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    ram[10'h23C] = 8'hA5;
    ram[10'h105] = 8'h3E;
    ram[10'h0A1] = 8'h5A;
    ram[10'h011] = 8'h07;
    ram[10'h012] = 8'h03;

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      bank_sel[u]  = 2'b00;
      req_valid[u] = 1'b0;
      req_addr[u]  = 8'h00;
      rsp_ready[u] = 1'b0;
    end

    #2;
    chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
    chk("rst_mem_en", 32'(mem_en[0]), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr[0]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data[0]), 32'd0);
    chk("rst_rsp_bank", 32'(rsp_bank[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_ready0", 32'(req_ready[0]), 32'd1);
    chk("release_ready1", 32'(req_ready[1]), 32'd1);

    do_read(0, 2'b10, 8'h3C, 0, 1'b0);
    do_read(0, 2'b01, 8'h05, 0, 1'b1);
    do_read(0, 2'b00, 8'hA1, 5, 1'b0);
    do_read(1, 2'b00, 8'hA1, 0, 1'b0);
    do_read(1, 2'b00, 8'h11, 0, 1'b0);
    do_read(0, 2'b00, 8'h12, 1, 1'b0);

    // Abort a read in WAIT on the latency-3 unit.
    bank_sel[1]  = 2'b01;
    req_addr[1]  = 8'h77;
    req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready[1]), 32'd0);
    chk("abort_mem_en", 32'(mem_en[1]), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr[1]), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("abort_rsp_data", 32'(rsp_data[1]), 32'd0);
    chk("abort_rsp_bank", 32'(rsp_bank[1]), 32'd0);
`ifdef BANK_READ_PARITY_EN
    chk("abort_rsp_parity", 32'(rsp_parity[1]), 32'd0);
`endif
    // A request offered only during reset and withdrawn must leave no trace.
    req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_release_ready", 32'(req_ready[1]), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid[1]), 32'd0);
      chk("abort_no_mem_en", 32'(mem_en[1]), 32'd0);
    end

    for (int n = 0; n < 24; n++) begin
      do_read($urandom_range(0, 1), 2'($urandom), 8'($urandom),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bank_read_controller.md
# bank_read_controller

Read-side companion to `memory_bank_selector`: accepts byte-address read requests, latches the currently selected 2-bit memory bank from the selector's `out_data`, and issues single-beat reads to the banked data RAM. It sits between the CPU load path and the RAM. It returns read data on a valid/ready response channel with full backpressure. The selector writes the bank register; this block consumes it at request acceptance.

## Interface
- `DATA_WIDTH`, 8, width of RAM word and response data
- `ADDR_WIDTH`, 8, in-bank address width
- `BANK_WIDTH`, 2, bank select width (matches selector)
- `READ_LATENCY`, 1, RAM cycles from `mem_en` to valid `mem_rdata`; legal range 1..4

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `bank_sel`  in  BANK_WIDTH  current bank, from selector `out_data`
- `req_valid`  in  1  read request valid
- `req_ready`  out  1  block can accept a request
- `req_addr`  in  ADDR_WIDTH  in-bank address
- `mem_en`  out  1  RAM read strobe, one cycle per read
- `mem_addr`  out  BANK_WIDTH+ADDR_WIDTH  `{bank, addr}`
- `mem_rdata`  in  DATA_WIDTH  RAM read data
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  consumer accepts response
- `rsp_data`  out  DATA_WIDTH  read data
- `rsp_bank`  out  BANK_WIDTH  bank the read was issued to
- `rsp_parity`  out  1  present only with `BANK_READ_PARITY_EN`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch `req_addr` and `bank_sel`, then go to ISSUE.
- ISSUE: `mem_en`=1 for exactly this cycle with `mem_addr={latched bank, latched addr}`. Load the latency counter with READ_LATENCY, then go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter reaches 1, capture `mem_rdata` into `rsp_data`, then go to RESP.
- RESP: `rsp_valid`=1. `rsp_data` and `rsp_bank` are held stable until `rsp_valid && rsp_ready`, then go to IDLE.
- `req_ready`=0 in every state except IDLE. Only one read is outstanding at a time.
- A `bank_sel` change after acceptance does not affect the in-flight read, because the latched bank is used.
- `mem_addr` holds its last value when `mem_en`=0.
- `mem_rdata` is ignored in every state except the capture cycle.

## Timing
- Reset values: `req_ready`=0 while `rst_n`=0, and 1 from the first cycle after release (IDLE). All of `mem_en`, `mem_addr`, `rsp_valid`, `rsp_data`, `rsp_bank` and `rsp_parity` reset to 0.
- Latency: request accepted at edge A; `mem_en` is high in cycle A+1; `rsp_valid` rises in cycle A+READ_LATENCY+2.
- Throughput: with `rsp_ready` held at 1, one read every READ_LATENCY+3 cycles.
- Stalled response: the block holds RESP indefinitely and does not accept new requests.
- Reset mid-operation (any state): the FSM returns to IDLE immediately. The pending read is discarded, and late `mem_rdata` is never presented.
- `req_valid` deasserted before acceptance is legal; nothing is latched.

## Configuration
- `BANK_READ_PARITY_EN` defined: the `rsp_parity` port exists and equals the XOR-reduction of `rsp_data`. It is registered together with `rsp_data` and resets to 0.
- Macro undefined: the `rsp_parity` port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `drfa_mem_pkg` contains:
  - the `BANK_WIDTH` and `ADDR_WIDTH` defaults, shared with `memory_bank_selector`;
  - the FSM state enum `bank_rd_state_t`;
  - the `MAX_READ_LATENCY` constant, 4.
- One sub-module, `read_latency_counter`: a loadable down-counter with a `last` flag, which keeps WAIT timing isolated.

## Test plan
- Reset release, then one request with `bank_sel`=2'b10 and `req_addr`=8'h3C, READ_LATENCY=1, RAM word 8'hA5 → `mem_en` pulses once with `mem_addr`=10'h23C, then `rsp_valid`=1 and `rsp_data`=8'hA5 three cycles after acceptance, with `rsp_bank`=2'b10.
- `bank_sel` changes from 2'b01 to 2'b11 in the cycle after acceptance of `req_addr`=8'h05 → `mem_addr`=10'h105 and `rsp_bank`=2'b01.
- `rsp_ready` held at 0 for 5 cycles in RESP → `rsp_valid` and `rsp_data` are stable, `req_ready`=0 and `mem_en`=0 throughout; after the handshake, `req_ready`=1 on the next cycle.
- READ_LATENCY=3, RAM returns 8'h5A → `rsp_valid` rises 5 cycles after acceptance with `rsp_data`=8'h5A.
- `rst_n` asserted in WAIT → all outputs go to 0 immediately; after release `req_ready`=1 and no `rsp_valid` appears for the aborted read.
- With `BANK_READ_PARITY_EN`, read data 8'h07 → `rsp_parity`=1; read data 8'h03 → `rsp_parity`=0.
